// File: rtl/lampfpu_exp_pkg.sv
// Shared constants, state encoding and helpers for the lampFPU natural-exponential unit.
// Fixed-point constants are scaled for a 16-bit fraction datapath.
package lampfpu_exp_pkg;

    localparam logic [15:0]        LAMP_EXP_INV_LN2 = 16'hB8AA;
    localparam logic [15:0]        LAMP_EXP_LN2     = 16'hB172;
    localparam logic signed [17:0] LAMP_EXP_C0      = 18'sh10000;
    localparam logic signed [17:0] LAMP_EXP_C1      = 18'sh10000;
    localparam logic signed [17:0] LAMP_EXP_C2      = 18'sh08000;
    localparam logic signed [17:0] LAMP_EXP_C3      = 18'sd10923;
    localparam logic signed [17:0] LAMP_EXP_C4      = 18'sd2731;

    // Biased exponent at which 1.f lands on the Q7.16 grid unshifted, and the saturation threshold
    localparam logic [8:0]         LAMP_EXP_E_ALIGN = 9'd118;
    localparam logic [8:0]         LAMP_EXP_E_SAT   = 9'd134;
    localparam logic signed [40:0] LAMP_EXP_K_HALF  = 41'sd1073741824;

    typedef enum logic [1:0] {
        EXP_IDLE   = 2'd0,
        EXP_REDUCE = 2'd1,
        EXP_POLY   = 2'd2,
        EXP_PACK   = 2'd3
    } ssExp;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [11:0] f;
    } expRes_t;

    function automatic expRes_t FUNC_calcInfNanResExp(
        input logic s_op,
        input logic isZ_op,
        input logic isInf_op,
        input logic isSNAN_op,
        input logic isQNAN_op
    );
        expRes_t res;
        res.s = 1'b0;
        res.e = 8'd0;
        res.f = 12'd0;
        if (isSNAN_op || isQNAN_op) begin
            res.e = 8'hFF;
            res.f = 12'h200;
        end else if (isInf_op) begin
            res.e = s_op ? 8'h00 : 8'hFF;
            res.f = 12'h000;
        end else if (isZ_op) begin
            res.e = 8'd127;
            res.f = 12'h400;
        end else begin
            res.e = 8'd0;
            res.f = 12'h000;
        end
        return res;
    endfunction

    // Horner coefficient consumed on iteration i is C[3-i]
    function automatic logic signed [17:0] FUNC_expCoef(input logic [1:0] iter);
        logic signed [17:0] c;
        case (iter)
            2'd0:    c = LAMP_EXP_C3;
            2'd1:    c = LAMP_EXP_C2;
            2'd2:    c = LAMP_EXP_C1;
            2'd3:    c = LAMP_EXP_C0;
            default: c = LAMP_EXP_C0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lampfpu_exp_mac.sv
// Combinational signed multiply-add a*b + c; with trunc_i the product is floored
// back to the fixed-point grid before the add.
module lampfpu_exp_mac #(
    parameter int unsigned FX_FRAC = 16
) (
    input  logic signed [17:0] a_i,
    input  logic signed [17:0] b_i,
    input  logic signed [25:0] c_i,
    input  logic               trunc_i,
    output logic signed [25:0] res_o
);

    logic signed [35:0] prod_s;
    logic signed [35:0] scaled_s;

    assign prod_s   = 36'(a_i) * 36'(b_i);
    assign scaled_s = trunc_i ? (prod_s >>> FX_FRAC) : prod_s;
    assign res_o    = 26'(scaled_s) + c_i;

endmodule

// File: rtl/lampfpu_exp.sv
// Multi-cycle bfloat16 e^x: range reduction, degree-4 Horner polynomial, pack as 2^k * e^r.
// Delivers a pre-rounding sign/exponent/extended mantissa to the shared post-normalization stage.
module lampfpu_exp
    import lampfpu_exp_pkg::*;
#(
    parameter int unsigned POLY_ITER = 4,
    parameter int unsigned FX_FRAC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        doExp_i,
    input  logic        s_op_i,
    input  logic [8:0]  extE_op1_i,
    input  logic [7:0]  extF_op1_i,
    input  logic        isZ_op_i,
    input  logic        isInf_op_i,
    input  logic        isSNAN_op_i,
    input  logic        isQNAN_op_i,
    output logic        s_res_o,
    output logic [7:0]  e_res_o,
    output logic [11:0] f_res_o,
    output logic        valid_o,
    output logic        isOverflow_o,
    output logic        isUnderflow_o,
    output logic        isToRound_o
);

    localparam logic [1:0] CNT_LAST = 2'(POLY_ITER - 1);

    ssExp               state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               op_s_q, op_z_q, op_inf_q, op_snan_q, op_qnan_q;
    logic [8:0]         op_e_q;
    logic [7:0]         op_f_q;
    logic               sat_q, sat_d;
    logic signed [8:0]  k_q, k_d;
    logic signed [17:0] r_q, r_d;
    logic signed [17:0] p_q, p_d;

    logic               s_res_q, s_res_d;
    logic [7:0]         e_res_q, e_res_d;
    logic [11:0]        f_res_q, f_res_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               rnd_q, rnd_d;

    logic               sat_s;
    logic [3:0]         sh_s;
    logic [22:0]        mag_s;
    logic signed [23:0] x_s;
    logic signed [40:0] kprod_s;
    logic signed [8:0]  k_s;

    logic signed [17:0] mac_a_s, mac_b_s;
    logic signed [25:0] mac_c_s, mac_res_s;
    logic               mac_trunc_s;

    logic               p_lt1_s;
    logic [16:0]        m_s;
    logic signed [9:0]  e_full_s;
    logic               ovf_s, unf_s, special_s;
    expRes_t            spec_res_s;

    // Within the aligned window e-118 is 0..15, so only the low nibble matters (118 = 0x76)
    assign sh_s = op_e_q[3:0] - 4'd6;

    // Operand to signed Q7.16 and k = round-half-up(X / ln2)
    always_comb begin
        sat_s = 1'b0;
        mag_s = 23'd0;
        if (op_e_q >= LAMP_EXP_E_SAT) begin
            sat_s = 1'b1;
        end else if (op_e_q < LAMP_EXP_E_ALIGN) begin
            mag_s = 23'd0;
        end else begin
            mag_s = 23'(op_f_q) << sh_s;
        end
        x_s     = op_s_q ? -$signed({1'b0, mag_s}) : $signed({1'b0, mag_s});
        kprod_s = 41'(x_s) * $signed({25'd0, LAMP_EXP_INV_LN2});
        k_s     = 9'((kprod_s + LAMP_EXP_K_HALF) >>> 5'd31);
    end

    // Shared MAC: REDUCE forms X - k*ln2, POLY forms p*r + C
    always_comb begin
        if (state_q == EXP_REDUCE) begin
            mac_a_s     = -(18'(k_s));
            mac_b_s     = $signed({2'b00, LAMP_EXP_LN2});
            mac_c_s     = 26'(x_s);
            mac_trunc_s = 1'b0;
        end else begin
            mac_a_s     = p_q;
            mac_b_s     = r_q;
            mac_c_s     = 26'(FUNC_expCoef(cnt_q));
            mac_trunc_s = 1'b1;
        end
    end

    lampfpu_exp_mac #(
        .FX_FRAC (FX_FRAC)
    ) u_mac (
        .a_i     (mac_a_s),
        .b_i     (mac_b_s),
        .c_i     (mac_c_s),
        .trunc_i (mac_trunc_s),
        .res_o   (mac_res_s)
    );

    // FSM next state and datapath register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        k_d     = k_q;
        r_d     = r_q;
        p_d     = p_q;
        case (state_q)
            EXP_IDLE: begin
                if (doExp_i) begin
                    state_d = EXP_REDUCE;
                end else begin
                    state_d = EXP_IDLE;
                end
            end
            EXP_REDUCE: begin
                state_d = EXP_POLY;
                cnt_d   = 2'd0;
                sat_d   = sat_s;
                k_d     = k_s;
                r_d     = 18'(mac_res_s);
                p_d     = LAMP_EXP_C4;
            end
            EXP_POLY: begin
                p_d = 18'(mac_res_s);
                if (cnt_q == CNT_LAST) begin
                    state_d = EXP_PACK;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            EXP_PACK: begin
                state_d = EXP_IDLE;
            end
            default: begin
                state_d = EXP_IDLE;
            end
        endcase
    end

    // Normalize p to 1.x, bias the exponent and build the result or the special override
    always_comb begin
        p_lt1_s = ~p_q[16];
        if (p_lt1_s) begin
            m_s      = 17'(p_q <<< 1);
            e_full_s = 10'(k_q) + 10'sd126;
        end else begin
            m_s      = 17'(p_q);
            e_full_s = 10'(k_q) + 10'sd127;
        end
        ovf_s      = (e_full_s >= 10'sd255) || (sat_q && !op_s_q);
        unf_s      = (e_full_s <= 10'sd0) || (sat_q && op_s_q);
        special_s  = op_z_q || op_inf_q || op_snan_q || op_qnan_q;
        spec_res_s = FUNC_calcInfNanResExp(op_s_q, op_z_q, op_inf_q, op_snan_q, op_qnan_q);

        valid_d = (state_q == EXP_PACK);
        s_res_d = s_res_q;
        e_res_d = e_res_q;
        f_res_d = f_res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        rnd_d   = rnd_q;
        if (state_q == EXP_PACK) begin
            if (special_s) begin
                s_res_d = spec_res_s.s;
                e_res_d = spec_res_s.e;
                f_res_d = spec_res_s.f;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                rnd_d   = 1'b0;
            end else begin
                s_res_d = 1'b0;
                e_res_d = e_full_s[7:0];
                f_res_d = {1'b0, m_s[16:7], |m_s[6:0]};
                ovf_d   = ovf_s;
                unf_d   = unf_s;
                rnd_d   = 1'b1;
            end
        end else begin
            s_res_d = s_res_q;
        end
    end

    // Operand capture on acceptance in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_s_q    <= 1'b0;
            op_e_q    <= 9'd0;
            op_f_q    <= 8'd0;
            op_z_q    <= 1'b0;
            op_inf_q  <= 1'b0;
            op_snan_q <= 1'b0;
            op_qnan_q <= 1'b0;
        end else if ((state_q == EXP_IDLE) && doExp_i) begin
            op_s_q    <= s_op_i;
            op_e_q    <= extE_op1_i;
            op_f_q    <= extF_op1_i;
            op_z_q    <= isZ_op_i;
            op_inf_q  <= isInf_op_i;
            op_snan_q <= isSNAN_op_i;
            op_qnan_q <= isQNAN_op_i;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EXP_IDLE;
            cnt_q   <= 2'd0;
            sat_q   <= 1'b0;
            k_q     <= 9'sd0;
            r_q     <= 18'sd0;
            p_q     <= 18'sd0;
            s_res_q <= 1'b0;
            e_res_q <= 8'd0;
            f_res_q <= 12'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rnd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            k_q     <= k_d;
            r_q     <= r_d;
            p_q     <= p_d;
            s_res_q <= s_res_d;
            e_res_q <= e_res_d;
            f_res_q <= f_res_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            rnd_q   <= rnd_d;
        end
    end

    assign s_res_o       = s_res_q;
    assign e_res_o       = e_res_q;
    assign f_res_o       = f_res_q;
    assign valid_o       = valid_q;
    assign isOverflow_o  = ovf_q;
    assign isUnderflow_o = unf_q;
    assign isToRound_o   = rnd_q;

endmodule

// File: tb/tb_lampfpu_exp.sv
// Scoreboard bench for lampfpu_exp: expected results come from real-valued e^x,
// a monitor pops and compares on every valid_o strobe.
module tb_lampfpu_exp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        doExp_i = 1'b0;
    logic        s_op_i = 1'b0;
    logic [8:0]  extE_op1_i = 9'd0;
    logic [7:0]  extF_op1_i = 8'd0;
    logic        isZ_op_i = 1'b0;
    logic        isInf_op_i = 1'b0;
    logic        isSNAN_op_i = 1'b0;
    logic        isQNAN_op_i = 1'b0;
    logic        s_res_o;
    logic [7:0]  e_res_o;
    logic [11:0] f_res_o;
    logic        valid_o;
    logic        isOverflow_o;
    logic        isUnderflow_o;
    logic        isToRound_o;

    always #5 clk = ~clk;

    lampfpu_exp #(
        .POLY_ITER (4),
        .FX_FRAC   (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .doExp_i       (doExp_i),
        .s_op_i        (s_op_i),
        .extE_op1_i    (extE_op1_i),
        .extF_op1_i    (extF_op1_i),
        .isZ_op_i      (isZ_op_i),
        .isInf_op_i    (isInf_op_i),
        .isSNAN_op_i   (isSNAN_op_i),
        .isQNAN_op_i   (isQNAN_op_i),
        .s_res_o       (s_res_o),
        .e_res_o       (e_res_o),
        .f_res_o       (f_res_o),
        .valid_o       (valid_o),
        .isOverflow_o  (isOverflow_o),
        .isUnderflow_o (isUnderflow_o),
        .isToRound_o   (isToRound_o)
    );

    // kind: 0 special (exact), 1 normal (within 1 ulp), 2 overflow, 3 underflow
    typedef struct {
        int         kind;
        bit [7:0]   e;
        bit [11:0]  f;
        int         idx;
        int         due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic exp_t ref_model(input bit s, input bit [8:0] ee, input bit [7:0] ff,
                                       input bit z, input bit inf, input bit sn, input bit qn);
        exp_t r;
        real  xr, l, eu, mant;
        r.kind = 0; r.e = 8'd0; r.f = 12'd0; r.idx = 0; r.due = 0;
        if (sn || qn) begin
            r.e = 8'hFF; r.f = 12'h200;
        end else if (inf) begin
            r.e = s ? 8'h00 : 8'hFF; r.f = 12'h000;
        end else if (z) begin
            r.e = 8'd127; r.f = 12'h400;
        end else begin
            xr = real'(ff) / 128.0 * $pow(2.0, real'(int'(ee) - 127));
            if (s) xr = -xr;
            if (xr >= 128.0) r.kind = 2;
            else if (xr <= -128.0) r.kind = 3;
            else begin
                l  = xr / $ln(2.0);
                eu = $floor(l);
                if (eu + 127.0 >= 255.0) r.kind = 2;
                else if (eu + 127.0 <= 0.0) r.kind = 3;
                else begin
                    mant   = $pow(2.0, l - eu);
                    r.kind = 1;
                    r.idx  = int'(eu + 127.0) * 128 + int'($floor((mant - 1.0) * 128.0));
                end
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t ex;
        int   act_idx;
        int   diff;
        if (valid_o === 1'b1) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: valid_o=1 at cycle %0d, required no result pending", cyc);
            end else begin
                ex = sb_q.pop_front();
                chk("latency", 64'(cyc), 64'(ex.due));
                chk("sign", 64'(s_res_o), 64'd0);
                if (ex.kind == 0) begin
                    chk("spec_e", 64'(e_res_o), 64'(ex.e));
                    chk("spec_f", 64'(f_res_o), 64'(ex.f));
                    chk("spec_ovf", 64'(isOverflow_o), 64'd0);
                    chk("spec_unf", 64'(isUnderflow_o), 64'd0);
                    chk("spec_round", 64'(isToRound_o), 64'd0);
                end else begin
                    chk("round", 64'(isToRound_o), 64'd1);
                    chk("ovf", 64'(isOverflow_o), (ex.kind == 2) ? 64'd1 : 64'd0);
                    chk("unf", 64'(isUnderflow_o), (ex.kind == 3) ? 64'd1 : 64'd0);
                    if (ex.kind == 1) begin
                        chk("hidden", 64'(f_res_o[11:10]), 64'd1);
                        act_idx = int'(e_res_o) * 128 + int'(f_res_o[9:3]);
                        diff    = act_idx - ex.idx;
                        checks++;
                        if (diff < -1 || diff > 1) begin
                            errors++;
                            $display("FAIL ulp: got e=%0d frac=%0d (index %0d) required index %0d +-1",
                                     e_res_o, f_res_o[9:3], act_idx, ex.idx);
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input bit s, input bit [8:0] ee, input bit [7:0] ff,
                         input bit z, input bit inf, input bit sn, input bit qn);
        s_op_i      = s;
        extE_op1_i  = ee;
        extF_op1_i  = ff;
        isZ_op_i    = z;
        isInf_op_i  = inf;
        isSNAN_op_i = sn;
        isQNAN_op_i = qn;
        doExp_i     = 1'b1;
    endtask

    task automatic scramble();
        doExp_i    = 1'b0;
        s_op_i     = 1'($urandom);
        extE_op1_i = 9'($urandom);
        extF_op1_i = 8'($urandom);
        isZ_op_i   = 1'($urandom);
    endtask

    task automatic expect_op(input bit s, input bit [8:0] ee, input bit [7:0] ff,
                             input bit z, input bit inf, input bit sn, input bit qn);
        exp_t ex;
        ex     = ref_model(s, ee, ff, z, inf, sn, qn);
        ex.due = cyc + 7;
        sb_q.push_back(ex);
        pushed++;
    endtask

    task automatic run_op(input bit s, input bit [8:0] ee, input bit [7:0] ff,
                          input bit z, input bit inf, input bit sn, input bit qn);
        @(negedge clk);
        drive(s, ee, ff, z, inf, sn, qn);
        expect_op(s, ee, ff, z, inf, sn, qn);
        @(posedge clk);
        #1 scramble();
        repeat (6) @(posedge clk);
    endtask

    task automatic run_random();
        int       cat;
        bit       s;
        bit [8:0] ee;
        bit [7:0] ff;
        cat = int'($urandom_range(0, 9));
        s   = 1'($urandom);
        ff  = {1'b1, 7'($urandom)};
        ee  = 9'($urandom_range(105, 140));
        case (cat)
            0:       run_op(s, 9'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            1:       run_op(s, 9'd255, ff, 1'b0, 1'b0, 1'($urandom), 1'b1);
            2:       run_op(s, 9'd255, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
            default: run_op(s, ee, ff, 1'b0, 1'b0, 1'b0, 1'b0);
        endcase
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_e", 64'(e_res_o), 64'd0);
        chk("reset_f", 64'(f_res_o), 64'd0);
        chk("reset_flags", 64'({isOverflow_o, isUnderflow_o, isToRound_o, s_res_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 9'd0,   8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 9'd127, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 9'd127, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 9'd133, 8'hC8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 9'd133, 8'hC8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 9'd134, 8'hC8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 9'd134, 8'hC8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 9'd255, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 9'd255, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(1'b1, 9'd255, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(1'b0, 9'd255, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(1'b1, 9'd0,   8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 9'd110, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 9'd118, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 9'd132, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) run_random();

        // Request pulsed mid-POLY must be dropped
        @(negedge clk);
        drive(1'b0, 9'd128, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_op(1'b0, 9'd128, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 scramble();
        repeat (2) @(posedge clk);
        #1 drive(1'b0, 9'd255, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 scramble();
        repeat (3) @(posedge clk);

        // Reset asserted in the third POLY cycle aborts the operation
        @(negedge clk);
        drive(1'b1, 9'd129, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 scramble();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(valid_o), 64'd0);
        chk("midreset_e", 64'(e_res_o), 64'd0);
        chk("midreset_f", 64'(f_res_o), 64'd0);
        chk("midreset_flags", 64'({isOverflow_o, isUnderflow_o, isToRound_o, s_res_o}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        run_op(1'b0, 9'd126, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 9'd129, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("pending_results", 64'(sb_q.size()), 64'd0);
        chk("valid_count", 64'(valid_cnt), 64'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
